lsu_controller: RTL

LSU_CONTROLLER -- requirements
Module: lsu_controller

---
 rtl/rv32i_pkg.sv | 40 ++++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings and the LSU request legality check.
package rv32i_pkg;

    typedef enum logic [6:0] {
        OpLoad  = 7'b0000011,
        OpStore = 7'b0100011
    } opcode_e;

    localparam logic [2:0] F3Byte  = 3'd0;
    localparam logic [2:0] F3Half  = 3'd1;
    localparam logic [2:0] F3Word  = 3'd2;
    localparam logic [2:0] F3ByteU = 3'd4;
    localparam logic [2:0] F3HalfU = 3'd5;

    // Unsigned widths have no meaning for stores, so BU/HU are rejected there.
    function automatic logic lsu_access_err(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic is_load;
        logic is_store;
        logic bad_f3;
        logic misal;
        is_load  = (op == OpLoad);
        is_store = (op == OpStore);
        bad_f3   = 1'b0;
        misal    = 1'b0;
        case (f3)
            F3Byte:  misal = 1'b0;
            F3Half:  misal = off[0];
            F3Word:  misal = (off != 2'b00);
            F3ByteU: bad_f3 = is_store;
            F3HalfU: begin
                bad_f3 = is_store;
                misal  = off[0];
            end
            default: bad_f3 = 1'b1;
        endcase
        return !(is_load || is_store) || bad_f3 || misal;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
module lsu_load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] value_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        value_o = rdata_i;
        case (funct3_i)
            F3Byte:  value_o = {{24{shifted[7]}}, shifted[7:0]};
            F3Half:  value_o = {{16{shifted[15]}}, shifted[15:0]};
            F3ByteU: value_o = {24'b0, shifted[7:0]};
            F3HalfU: value_o = {16'b0, shifted[15:0]};
            default: value_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Single-outstanding load/store unit: latches a request, drives one memory
// access and reports completion (or a rejected request) with a done pulse.
module lsu_controller
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [6:0]  op_code_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] address_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] load_data_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic        mem_re_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o
);

    typedef enum logic [2:0] {
        StIdle,
        StStore,
        StLoadReq,
        StLoadWait,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic        err_q;
    logic [31:0] load_data_q;
    logic        latch_en;
    logic        req_err;
    logic [31:0] align_value;

    assign req_err = lsu_access_err(op_code_i, funct3_i, address_i[1:0]);

    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    latch_en = 1'b1;
                    if (req_err) begin
                        state_d = StDone;
                    end else if (op_code_i == OpStore) begin
                        state_d = StStore;
                    end else begin
                        state_d = StLoadReq;
                    end
                end
            end
            StStore:    state_d = StDone;
            StLoadReq:  state_d = StLoadWait;
            StLoadWait: state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            f3_q        <= 3'b0;
            addr_q      <= 32'b0;
            sdata_q     <= 32'b0;
            err_q       <= 1'b0;
            load_data_q <= 32'b0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                f3_q    <= funct3_i;
                addr_q  <= address_i;
                sdata_q <= store_data_i;
                err_q   <= req_err;
            end
            // Read data is valid exactly one cycle after the read strobe.
            if (state_q == StLoadWait) begin
                load_data_q <= align_value;
            end
        end
    end

    lsu_load_align u_load_align (
        .rdata_i  (mem_rdata_i),
        .off_i    (addr_q[1:0]),
        .funct3_i (f3_q),
        .value_o  (align_value)
    );

    always_comb begin
        busy_o      = (state_q != StIdle);
        done_o      = (state_q == StDone);
        error_o     = (state_q == StDone) && err_q;
        mem_we_o    = (state_q == StStore);
        mem_re_o    = (state_q == StLoadReq);
        mem_addr_o  = 32'b0;
        mem_wmask_o = 4'b0;
        mem_wdata_o = 32'b0;
        if (mem_we_o || mem_re_o) begin
            mem_addr_o = {addr_q[31:2], 2'b00};
        end
        if (mem_we_o) begin
            case (f3_q)
                F3Byte: begin
                    mem_wmask_o = 4'b0001 << addr_q[1:0];
                    mem_wdata_o = {4{sdata_q[7:0]}};
                end
                F3Half: begin
                    mem_wmask_o = 4'b0011 << addr_q[1:0];
                    mem_wdata_o = {2{sdata_q[15:0]}};
                end
                default: begin
                    mem_wmask_o = 4'b1111;
                    mem_wdata_o = sdata_q;
                end
            endcase
        end
    end

    assign load_data_o = load_data_q;

endmodule
